// File: rtl/edg_zbt_writer_pkg.sv
// Shared types and widths for the edge-pipeline ZBT write-back stage.
// Optional statistics output is enabled by defining EDG_WR_STATS_EN.
package edg_pkg;

  localparam int PIX_W      = 18;
  localparam int PAIR_W     = 2 * PIX_W;
  localparam int ZBT_ADDR_W = 19;

  typedef struct packed {
    logic [ZBT_ADDR_W-1:0] addr;
    logic [PAIR_W-1:0]     pix;
  } wr_entry_t;

endpackage

// File: rtl/edg_zbt_writer_if.sv
// Pixel-pair input, arbiter grant and ZBT bank-1 write bus of the write-back stage.
// master = producer/observer side, slave = edg_zbt_writer.
interface edg_zbt_writer_if #(
  parameter int DEPTH = 16
) ();
  import edg_pkg::*;

  logic                      in_valid;
  logic [PAIR_W-1:0]         in_pix;
  logic [ZBT_ADDR_W-1:0]     in_addr;
  logic                      wr_slot;
  logic                      zbt_we;
  logic [ZBT_ADDR_W-1:0]     zbt_addr;
  logic [PAIR_W-1:0]         zbt_data;
  logic                      zbt_data_oe;
  logic                      fifo_full;
  logic [$clog2(DEPTH):0]    fifo_level;
  logic                      overflow;

  modport master (
    output in_valid, in_pix, in_addr, wr_slot,
    input  zbt_we, zbt_addr, zbt_data, zbt_data_oe, fifo_full, fifo_level, overflow
  );

  modport slave (
    input  in_valid, in_pix, in_addr, wr_slot,
    output zbt_we, zbt_addr, zbt_data, zbt_data_oe, fifo_full, fifo_level, overflow
  );

endinterface

// File: rtl/edg_zbt_writer_fifo.sv
// Synchronous FIFO of wr_entry_t with an explicit occupancy counter (0..DEPTH).
// The caller guarantees push only when not full or when popping in the same cycle.
module edg_wr_fifo
  import edg_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  wr_entry_t              push_data,
  input  logic                   pop,
  output wr_entry_t              pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW + 1)'(DEPTH);

  wr_entry_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     level_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the occupancy counter alone defines valid entries.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
  assign level    = level_q;
  assign full     = (level_q == LVL_FULL);
  assign empty    = (level_q == '0);

endmodule

// File: rtl/edg_zbt_writer.sv
// ZBT bank-1 write-back stage: buffers pixel pairs, issues them in arbiter write slots
// with address/WE first and data WR_LAT cycles later. EDG_WR_STATS_EN adds drop_count.
module edg_zbt_writer
  import edg_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int WR_LAT = 2
) (
  input  logic             clk,
  input  logic             reset,
  edg_zbt_writer_if.slave  bus
`ifdef EDG_WR_STATS_EN
  ,
  output logic [15:0]      drop_count
`endif
);

  wr_entry_t             push_data;
  wr_entry_t             pop_data;
  logic                  full;
  logic                  empty;
  logic                  pop;
  logic                  push;
  logic                  drop;
  logic [$clog2(DEPTH):0] level;

  // Pop decision uses occupancy at cycle start, so a same-cycle push is never bypassed.
  assign pop  = bus.wr_slot && !empty;
  assign push = bus.in_valid && (!full || pop);
  assign drop = bus.in_valid && full && !pop;

  assign push_data = '{addr: bus.in_addr, pix: bus.in_pix};

  edg_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  logic [PAIR_W-1:0] issue_pix;

  // Address is held between writes; only the data bus returns to zero when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.zbt_we   <= 1'b0;
      bus.zbt_addr <= '0;
      issue_pix    <= '0;
    end else begin
      bus.zbt_we <= pop;
      if (pop) begin
        bus.zbt_addr <= pop_data.addr;
        issue_pix    <= pop_data.pix;
      end
    end
  end

  logic [WR_LAT-1:0] oe_pipe;
  logic [PAIR_W-1:0] data_pipe [WR_LAT];

  // Clearing this pipeline on reset abandons any write still waiting for its data phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WR_LAT; i++) begin
        oe_pipe[i]   <= 1'b0;
        data_pipe[i] <= '0;
      end
    end else begin
      oe_pipe[0]   <= bus.zbt_we;
      data_pipe[0] <= bus.zbt_we ? issue_pix : '0;
      for (int i = 1; i < WR_LAT; i++) begin
        oe_pipe[i]   <= oe_pipe[i-1];
        data_pipe[i] <= data_pipe[i-1];
      end
    end
  end

  assign bus.zbt_data_oe = oe_pipe[WR_LAT-1];
  assign bus.zbt_data    = data_pipe[WR_LAT-1];
  assign bus.fifo_full   = full;
  assign bus.fifo_level  = level;

  always_ff @(posedge clk) begin
    if (reset)     bus.overflow <= 1'b0;
    else if (drop) bus.overflow <= 1'b1;
  end

`ifdef EDG_WR_STATS_EN
  always_ff @(posedge clk) begin
    if (reset)                             drop_count <= '0;
    else if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_edg_zbt_writer.sv
// Randomized and directed bench for edg_zbt_writer against a queue-based reference model.
// Define EDG_WR_STATS_EN to also exercise drop_count.
module tb_edg_zbt_writer;
  import edg_pkg::*;

  localparam int DEPTH  = 16;
  localparam int WR_LAT = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  edg_zbt_writer_if #(.DEPTH(DEPTH)) bus ();

`ifdef EDG_WR_STATS_EN
  logic [15:0] drop_count;
`endif

  edg_zbt_writer #(.DEPTH(DEPTH), .WR_LAT(WR_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef EDG_WR_STATS_EN
    ,
    .drop_count (drop_count)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: queue of pending entries plus a ring of expected bus values per cycle.
  wr_entry_t             q[$];
  logic                  exp_we   [8];
  logic [ZBT_ADDR_W-1:0] exp_addr [8];
  logic                  exp_oe   [8];
  logic [PAIR_W-1:0]     exp_data [8];
  int                    exp_level = 0;
  logic                  exp_ovf   = 1'b0;
  int                    exp_drops = 0;
  int                    c = 0;

  task automatic step(input logic v, input logic [PAIR_W-1:0] p, input logic [ZBT_ADDR_W-1:0] a,
                      input logic s, input logic r);
    int cur, nxt, dat;
    bit pop;
    wr_entry_t e;
    @(negedge clk);
    cur = c % 8;
    nxt = (c + 1) % 8;
    dat = (c + 1 + WR_LAT) % 8;
    check("zbt_we",      bus.zbt_we,      exp_we[cur]);
    check("zbt_addr",    bus.zbt_addr,    exp_addr[cur]);
    check("zbt_data_oe", bus.zbt_data_oe, exp_oe[cur]);
    check("zbt_data",    bus.zbt_data,    exp_data[cur]);
    check("fifo_level",  bus.fifo_level,  exp_level);
    check("fifo_full",   bus.fifo_full,   exp_level == DEPTH);
    check("overflow",    bus.overflow,    exp_ovf);
`ifdef EDG_WR_STATS_EN
    check("drop_count",  drop_count,      exp_drops);
`endif
    exp_oe[cur]   = 1'b0;
    exp_data[cur] = '0;

    reset        = r;
    bus.in_valid = v;
    bus.in_pix   = p;
    bus.in_addr  = a;
    bus.wr_slot  = s;

    if (r) begin
      q.delete();
      for (int i = 0; i < 8; i++) begin
        exp_oe[i]   = 1'b0;
        exp_data[i] = '0;
      end
      exp_we[nxt]   = 1'b0;
      exp_addr[nxt] = '0;
      exp_ovf       = 1'b0;
      exp_drops     = 0;
    end else begin
      pop = s && (q.size() > 0);
      exp_we[nxt]   = pop;
      exp_addr[nxt] = exp_addr[cur];
      if (pop) begin
        e = q.pop_front();
        exp_addr[nxt] = e.addr;
        exp_oe[dat]   = 1'b1;
        exp_data[dat] = e.pix;
      end
      if (v) begin
        if (q.size() < DEPTH) begin
          e.addr = a;
          e.pix  = p;
          q.push_back(e);
        end else begin
          exp_ovf = 1'b1;
          if (exp_drops < 65535) exp_drops++;
        end
      end
    end
    exp_level = q.size();
    c++;
  endtask

  task automatic idle(input int n, input logic s);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, s, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, '0, '0, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  function automatic logic [PAIR_W-1:0] rnd_pix();
    return {$urandom_range(0, 15), $urandom()};
  endfunction

  initial begin
    for (int i = 0; i < 8; i++) begin
      exp_we[i] = 1'b0; exp_addr[i] = '0; exp_oe[i] = 1'b0; exp_data[i] = '0;
    end
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_pix = '0; bus.in_addr = '0; bus.wr_slot = 1'b0;
    repeat (2) @(posedge clk);
    do_reset();

    // Single write with slot held high.
    step(1'b1, 36'h2_AAAA_5555, 19'h00010, 1'b1, 1'b0);
    idle(8, 1'b1);

    // Fill with no slots, one extra dropped, then drain in order.
    for (int i = 0; i < DEPTH + 1; i++)
      step(1'b1, rnd_pix(), 19'(i), 1'b0, 1'b0);
    idle(DEPTH + 6, 1'b1);

    // Full FIFO with simultaneous push and pop: no drop.
    do_reset();
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, rnd_pix(), 19'(i + 32), 1'b0, 1'b0);
    step(1'b1, rnd_pix(), 19'h00100, 1'b1, 1'b0);
    idle(2, 1'b0);
    idle(DEPTH + 5, 1'b1);

    // Alternating slots with continuous input.
    for (int i = 0; i < 40; i++)
      step(1'b1, rnd_pix(), 19'(i + 200), 1'(i % 2 == 0), 1'b0);
    idle(DEPTH * 2 + 5, 1'b1);

    // Reset one cycle after a pop abandons the in-flight write.
    do_reset();
    step(1'b1, rnd_pix(), 19'h7_0001, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    idle(6, 1'b1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) != 0, rnd_pix(), 19'($urandom()),
           $urandom_range(0, 2) == 0 ? 1'b0 : ((i / 64) % 3 != 0),
           $urandom_range(0, 499) == 0);
    idle(DEPTH + 6, 1'b1);

`ifdef EDG_WR_STATS_EN
    do_reset();
    for (int i = 0; i < DEPTH + 3; i++)
      step(1'b1, rnd_pix(), 19'(i), 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0);
    check("drop_count_3", drop_count, 16'd3);
    for (int i = 0; i < 70000; i++)
      step(1'b1, rnd_pix(), 19'(i), 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0);
    check("drop_count_sat", drop_count, 16'hFFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
